// File: rtl/key_pkg.sv
// key_pkg: shared types and board defaults for the pushbutton debouncer.
//   deb_state_t        per-lane stability FSM state
//   DEF_*              defaults for the 50 MHz DE board (10 ms debounce,
//                      250 ms first repeat, 100 ms repeat period)
//   max_u()            helper for sizing counters from two cycle counts
package key_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } deb_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_REPEAT_DELAY    = 12500000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_lane.sv
// key_debounce_lane: one key's 2-flop synchroniser, stability FSM, counter,
// registered press/release pulses and (optionally) auto-repeat strobe.
// Optional feature macro: KEY_DEBOUNCE_REPEAT_EN (hold counter + repeat_pulse).
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   key_raw        raw active-low pin, asynchronous to clk
//   key_clean      debounced active-low level
//   press_pulse    one cycle high when key_clean goes 1->0
//   release_pulse  one cycle high when key_clean goes 0->1
//   repeat_pulse   auto-repeat strobe while held (0 without the feature)
module key_debounce_lane
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_DEBOUNCE_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value seen on the edge that completes DEBOUNCE_CYCLES mismatches.
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    deb_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            clean_q, clean_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            mismatch;
    logic            accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    assign mismatch = (sync2_q != clean_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (mismatch) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // Single-cycle debounce: first mismatch is accepted directly.
                        accept = 1'b1;
                    end else begin
                        state_d = CHECK;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            CHECK: begin
                if (!mismatch) begin
                    // Glitch shorter than the window: drop it silently.
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    accept  = 1'b1;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    always_comb begin
        clean_d   = accept ? sync2_q : clean_q;
        press_d   = accept & ~sync2_q;
        release_d = accept & sync2_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= STABLE;
            cnt_q     <= '0;
            clean_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_clean     = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int unsigned HoldW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    // hold_q counts edges since the press (or since the last repeat); a repeat
    // fires on the edge where it would reach the delay/period.
    localparam logic [HoldW-1:0] DelayLast  = HoldW'(REPEAT_DELAY - 1);
    localparam logic [HoldW-1:0] PeriodLast = HoldW'(REPEAT_PERIOD - 1);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             armed_q, armed_d;
    logic             repeat_q, repeat_d;

    always_comb begin
        hold_d   = hold_q;
        armed_d  = armed_q;
        repeat_d = 1'b0;
        // While released, or on the release edge itself, the hold state clears;
        // this also keeps a repeat off the release edge and the press edge.
        if (clean_q || accept) begin
            hold_d  = '0;
            armed_d = 1'b0;
        end else if (hold_q == (armed_q ? PeriodLast : DelayLast)) begin
            repeat_d = 1'b1;
            hold_d   = '0;
            armed_d  = 1'b1;
        end else begin
            hold_d = hold_q + HoldW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q   <= '0;
            armed_q  <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            armed_q  <= armed_d;
            repeat_q <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces N_KEYS active-low pushbuttons and
// produces one-cycle press/release strobes for the game controller.
// Optional feature macro: KEY_DEBOUNCE_REPEAT_EN (auto-repeat while held).
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   KEY            raw pushbutton pins, active-low, asynchronous to clk
//   key_clean      debounced active-low levels
//   press_pulse    one cycle high per lane when key_clean goes 1->0
//   release_pulse  one cycle high per lane when key_clean goes 0->1
//   repeat_pulse   auto-repeat strobes (all 0 without the feature)
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_clean,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse
);

    // Elaboration-time parameter sanity.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("key_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
        key_debounce_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_DEBOUNCE_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_lane (
            .clk           (clk),
            .reset         (reset),
            .key_raw       (KEY[i]),
            .key_clean     (key_clean[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

    localparam int unsigned N  = 4;
    localparam int unsigned D  = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned RP = 4;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam bit RepEn = 1'b1;
`else
    localparam bit RepEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] KEY = '1;
    logic [N-1:0] key_clean, press_pulse, release_pulse, repeat_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    key_debounce #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .KEY           (KEY),
        .key_clean     (key_clean),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    // Advance one active edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_clean, exp_pulse;
        reset = 1'b0;
        KEY   = 4'b0000;
        repeat (3) tick();
        tests_run++;
        if (key_clean !== 4'b1111) begin
            tests_failed++;
            $display("FAIL reset_clean: got %b expected 1111", key_clean);
        end
        tests_run++;
        if ({press_pulse, release_pulse, repeat_pulse} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_pulses: got %b/%b/%b expected all 0",
                     press_pulse, release_pulse, repeat_pulse);
        end
        // Release reset with keys already held low: press at edge D+1.
        reset = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_clean = (e >= 5) ? 4'b0000 : 4'b1111;
            exp_pulse = (e == 5) ? 4'b1111 : 4'b0000;
            tests_run++;
            if (key_clean !== exp_clean || press_pulse !== exp_pulse) begin
                tests_failed++;
                $display("FAIL reset_release edge %0d: clean=%b press=%b expected %b %b",
                         e, key_clean, press_pulse, exp_clean, exp_pulse);
            end
        end
        KEY = 4'b1111;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_clean = (e >= 5) ? 4'b1111 : 4'b0000;
            exp_pulse = (e == 5) ? 4'b1111 : 4'b0000;
            tests_run++;
            if (key_clean !== exp_clean || release_pulse !== exp_pulse) begin
                tests_failed++;
                $display("FAIL reset_unpress edge %0d: clean=%b release=%b expected %b %b",
                         e, key_clean, release_pulse, exp_clean, exp_pulse);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] exp_clean, exp_pulse;
        KEY = 4'b1101;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_clean = (e >= 5) ? 4'b1101 : 4'b1111;
            exp_pulse = (e == 5) ? 4'b0010 : 4'b0000;
            tests_run++;
            if (key_clean !== exp_clean || press_pulse !== exp_pulse ||
                release_pulse !== 4'b0000) begin
                tests_failed++;
                $display("FAIL clean_press edge %0d: clean=%b press=%b release=%b expected %b %b 0000",
                         e, key_clean, press_pulse, release_pulse, exp_clean, exp_pulse);
            end
        end
        KEY = 4'b1111;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_clean = (e >= 5) ? 4'b1111 : 4'b1101;
            exp_pulse = (e == 5) ? 4'b0010 : 4'b0000;
            tests_run++;
            if (key_clean !== exp_clean || release_pulse !== exp_pulse ||
                press_pulse !== 4'b0000) begin
                tests_failed++;
                $display("FAIL clean_release edge %0d: clean=%b release=%b press=%b expected %b %b 0000",
                         e, key_clean, release_pulse, press_pulse, exp_clean, exp_pulse);
            end
        end
    endtask

    task automatic test_bounce();
        bit pat [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                         1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int presses;
        for (int i = 0; i < 12; i++) begin
            KEY[2] = pat[i];
            tick();
            tests_run++;
            if (key_clean !== 4'b1111 || press_pulse !== 4'b0000 ||
                release_pulse !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bounce step %0d: clean=%b press=%b release=%b expected 1111 0000 0000",
                         i, key_clean, press_pulse, release_pulse);
            end
        end
        presses = 0;
        KEY[2]  = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (press_pulse[2]) presses++;
            if (e == 5) begin
                tests_run++;
                if (press_pulse !== 4'b0100) begin
                    tests_failed++;
                    $display("FAIL bounce_press_edge: press=%b expected 0100", press_pulse);
                end
            end
        end
        tests_run++;
        if (presses != 1 || key_clean !== 4'b1011) begin
            tests_failed++;
            $display("FAIL bounce_settle: presses=%0d clean=%b expected 1 1011",
                     presses, key_clean);
        end
        KEY = 4'b1111;
        repeat (7) tick();
        tests_run++;
        if (key_clean !== 4'b1111) begin
            tests_failed++;
            $display("FAIL bounce_release: clean=%b expected 1111", key_clean);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_pulse;
        KEY = 4'b0000;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_pulse = (e == 5) ? 4'b1111 : 4'b0000;
            tests_run++;
            if (press_pulse !== exp_pulse || release_pulse !== 4'b0000) begin
                tests_failed++;
                $display("FAIL simul_press edge %0d: press=%b release=%b expected %b 0000",
                         e, press_pulse, release_pulse, exp_pulse);
            end
        end
        KEY = 4'b1111;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_pulse = (e == 5) ? 4'b1111 : 4'b0000;
            tests_run++;
            if (release_pulse !== exp_pulse || press_pulse !== 4'b0000) begin
                tests_failed++;
                $display("FAIL simul_release edge %0d: release=%b press=%b expected %b 0000",
                         e, release_pulse, press_pulse, exp_pulse);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_clean, exp_pulse;
        KEY = 4'b0000;
        repeat (6) tick();
        tests_run++;
        if (press_pulse !== 4'b1111 || key_clean !== 4'b0000) begin
            tests_failed++;
            $display("FAIL areset_setup: press=%b clean=%b expected 1111 0000",
                     press_pulse, key_clean);
        end
        // Assert reset between edges: outputs must clear without a clock.
        reset = 1'b0;
        #1;
        tests_run++;
        if (key_clean !== 4'b1111 || press_pulse !== 4'b0000) begin
            tests_failed++;
            $display("FAIL areset_immediate: clean=%b press=%b expected 1111 0000",
                     key_clean, press_pulse);
        end
        tick();
        reset = 1'b1;
        repeat (3) tick();
        // Lanes are now mid-CHECK; reset again without a clock edge.
        reset = 1'b0;
        #1;
        tests_run++;
        if (key_clean !== 4'b1111 || press_pulse !== 4'b0000) begin
            tests_failed++;
            $display("FAIL areset_midcheck: clean=%b press=%b expected 1111 0000",
                     key_clean, press_pulse);
        end
        tick();
        reset = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_clean = (e >= 5) ? 4'b0000 : 4'b1111;
            exp_pulse = (e == 5) ? 4'b1111 : 4'b0000;
            tests_run++;
            if (key_clean !== exp_clean || press_pulse !== exp_pulse) begin
                tests_failed++;
                $display("FAIL areset_restart edge %0d: clean=%b press=%b expected %b %b",
                         e, key_clean, press_pulse, exp_clean, exp_pulse);
            end
        end
        KEY = 4'b1111;
        repeat (7) tick();
    endtask

    task automatic test_repeat();
        logic [3:0] exp_rep;
        KEY = 4'b0111;
        for (int e = 0; e <= 35; e++) begin
            tick();
            exp_rep = (RepEn && e >= 13 && ((e - 13) % 4) == 0) ? 4'b1000 : 4'b0000;
            tests_run++;
            if (repeat_pulse !== exp_rep) begin
                tests_failed++;
                $display("FAIL repeat_hold edge %0d: repeat=%b expected %b",
                         e, repeat_pulse, exp_rep);
            end
            if (e == 5) begin
                tests_run++;
                if (press_pulse !== 4'b1000) begin
                    tests_failed++;
                    $display("FAIL repeat_press: press=%b expected 1000", press_pulse);
                end
            end
        end
        // A repeat would land on the release edge (e == 5); it must not fire.
        KEY = 4'b1111;
        for (int e = 0; e <= 9; e++) begin
            tick();
            exp_rep = (RepEn && e == 1) ? 4'b1000 : 4'b0000;
            tests_run++;
            if (repeat_pulse !== exp_rep) begin
                tests_failed++;
                $display("FAIL repeat_release edge %0d: repeat=%b expected %b",
                         e, repeat_pulse, exp_rep);
            end
            if (e == 5) begin
                tests_run++;
                if (release_pulse !== 4'b1000) begin
                    tests_failed++;
                    $display("FAIL repeat_release_pulse: release=%b expected 1000",
                             release_pulse);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_async_reset();
        test_repeat();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
